// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the MiniMIPS32 five-stage pipeline.
// Optional perf counters are built only when PIPE_STALL_CNT_EN is defined.
`ifndef PC_INIT
`define PC_INIT 32'hBFC00000
`endif

module pipeline_ctrl #(
    parameter int STALL_W = 6,
    parameter int PC_W    = 32
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               stallreq_id,
    input  logic               stallreq_exe,
    input  logic               ibus_req,
    input  logic               ibus_data_ok,
    input  logic               dbus_req,
    input  logic               dbus_data_ok,
    input  logic               exc_valid,
    input  logic [PC_W-1:0]    exc_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [PC_W-1:0]    flush_pc,
    output logic               ibus_drop,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
);

    localparam logic [STALL_W-1:0] STALL_DBUS = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] STALL_EXE  = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_IBUS = STALL_W'(6'b000011);

    typedef enum logic [1:0] {RUN, DWAIT, DFLUSH} state_t;

    state_t          state;
    logic [PC_W-1:0] exc_hold;
    logic            discard;

    logic dbus_wait;
    logic ibus_wait;
    logic hold_dbus;
    logic take_exc;
    logic fire;

    // Bus handshake: *_req stays high while a transaction is open; the
    // matching *_data_ok pulses for exactly one cycle when it completes.
    always_comb begin
        dbus_wait = dbus_req & ~dbus_data_ok;
        ibus_wait = (ibus_req | discard) & ~ibus_data_ok;
        hold_dbus = (state == RUN) ? dbus_wait : ~dbus_data_ok;
        take_exc  = exc_valid & (state != DFLUSH);
        fire      = ((state == DFLUSH) & dbus_data_ok) | (take_exc & ~hold_dbus);

        stall     = '0;
        flush     = 1'b0;
        flush_pc  = '0;
        ibus_drop = 1'b0;
        if (cpu_rst_n) begin
            flush_pc = PC_W'(`PC_INIT);
        end else begin
            flush     = fire;
            ibus_drop = ibus_data_ok & (discard | fire);
            if (fire)
                flush_pc = (state == DFLUSH) ? exc_hold : exc_pc;
            else if (hold_dbus)
                stall = STALL_DBUS;
            else if (stallreq_exe)
                stall = STALL_EXE;
            else if (stallreq_id)
                stall = STALL_ID;
            else if (ibus_wait)
                stall = STALL_IBUS;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n) begin
            state    <= RUN;
            exc_hold <= '0;
            discard  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (take_exc && hold_dbus) begin
                        exc_hold <= exc_pc;
                        state    <= DFLUSH;
                    end else if (dbus_wait) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (take_exc && hold_dbus) begin
                        exc_hold <= exc_pc;
                        state    <= DFLUSH;
                    end else if (dbus_data_ok) begin
                        state <= RUN;
                    end
                end
                DFLUSH: begin
                    // The first exception owns the redirect; later ones are dropped.
                    if (dbus_data_ok)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase

            // A fetch still in flight at flush time returns stale data.
            if (ibus_data_ok)
                discard <= 1'b0;
            else if (fire && ibus_req)
                discard <= 1'b1;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall[0])
                stall_cnt <= stall_cnt + 32'd1;
            if (flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_cycles = cpu_rst_n ? 32'd0 : stall_cnt;
    assign flush_count  = cpu_rst_n ? 32'd0 : flush_cnt;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model.
`ifndef PC_INIT
`define PC_INIT 32'hBFC00000
`endif

module tb_pipeline_ctrl;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n;
    logic        stallreq_id, stallreq_exe;
    logic        ibus_req, ibus_data_ok, dbus_req, dbus_data_ok;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ibus_drop;
    logic [31:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PC_RST = `PC_INIT;

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    pipeline_ctrl dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .stallreq_id (stallreq_id),
        .stallreq_exe(stallreq_exe),
        .ibus_req    (ibus_req),
        .ibus_data_ok(ibus_data_ok),
        .dbus_req    (dbus_req),
        .dbus_data_ok(dbus_data_ok),
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .ibus_drop   (ibus_drop),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );

    // Drive one cycle of inputs just after the edge, then wait to the sampling point.
    task automatic apply(input logic rst, input logic id, input logic exe,
                         input logic ireq, input logic iok, input logic dreq,
                         input logic dok, input logic exc, input logic [31:0] pc);
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst_n = rst; stallreq_id = id; stallreq_exe = exe;
        ibus_req = ireq; ibus_data_ok = iok; dbus_req = dreq; dbus_data_ok = dok;
        exc_valid = exc; exc_pc = pc;
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_reset;
        apply(1, 1, 1, 1, 0, 1, 0, 1, 32'h12345678);
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b exp %b", stall, 6'b0); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
        checks++; if (flush_pc !== PC_RST) begin errors++; $display("FAIL reset_flush_pc got %h exp %h", flush_pc, PC_RST); end
        checks++; if (ibus_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", ibus_drop); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_scnt got %0d exp 0", stall_cycles); end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL post_reset_stall got %b exp 0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL post_reset_flush got %b exp 0", flush); end
        checks++; if (flush_count !== 32'd0) begin errors++; $display("FAIL post_reset_fcnt got %0d exp 0", flush_count); end
    endtask

    task automatic test_id_stall;
        logic [5:0] exp_s;
        for (int i = 0; i < 4; i++) begin
            apply(0, (i < 2), 0, 0, 0, 0, 0, 0, 32'h0);
            exp_s = (i < 2) ? 6'b000111 : 6'b000000;
            checks++; if (stall !== exp_s) begin errors++; $display("FAIL id_stall[%0d] got %b exp %b", i, stall, exp_s); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL id_flush[%0d] got %b exp 0", i, flush); end
        end
    endtask

    task automatic test_exe_priority;
        apply(0, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL exe_over_id got %b exp 001111", stall); end
        apply(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL exe_drop got %b exp 000111", stall); end
        apply(0, 1, 1, 1, 0, 1, 0, 0, 32'h0);
        checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL dbus_over_all got %b exp 011111", stall); end
        apply(0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL dbus_ack got %b exp 000000", stall); end
    endtask

    task automatic test_dbus_exc;
        for (int c = 1; c <= 4; c++) begin
            apply(0, 0, 0, 0, 0, 1, (c == 4), (c == 2), (c == 2) ? 32'hBFC00380 : 32'h0);
            if (c < 4) begin
                checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL dexc_stall[%0d] got %b exp 011111", c, stall); end
                checks++; if (flush !== 1'b0) begin errors++; $display("FAIL dexc_noflush[%0d] got %b exp 0", c, flush); end
            end else begin
                checks++; if (flush !== 1'b1) begin errors++; $display("FAIL dexc_flush got %b exp 1", flush); end
                checks++; if (flush_pc !== 32'hBFC00380) begin errors++; $display("FAIL dexc_pc got %h exp bfc00380", flush_pc); end
                checks++; if (stall !== 6'b0) begin errors++; $display("FAIL dexc_ack_stall got %b exp 0", stall); end
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL dexc_after got %b exp 0", flush); end
    endtask

    task automatic test_ibus_flush;
        apply(0, 0, 0, 1, 0, 0, 0, 1, 32'h80000180);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL iflush_flush got %b exp 1", flush); end
        checks++; if (flush_pc !== 32'h80000180) begin errors++; $display("FAIL iflush_pc got %h exp 80000180", flush_pc); end
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL iflush_stall got %b exp 0", stall); end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, (i == 2), 0, 0, 0, 32'h0);
            checks++; if (ibus_drop !== (i == 2)) begin errors++; $display("FAIL iflush_drop[%0d] got %b exp %b", i, ibus_drop, (i == 2)); end
            checks++; if (stall !== ((i == 2) ? 6'b0 : 6'b000011)) begin errors++; $display("FAIL iflush_wait[%0d] got %b", i, stall); end
        end
        apply(0, 0, 0, 1, 1, 0, 0, 1, 32'h80000200);
        checks++; if (ibus_drop !== 1'b1) begin errors++; $display("FAIL iflush_same_drop got %b exp 1", ibus_drop); end
        apply(0, 0, 0, 1, 1, 0, 0, 0, 32'h0);
        checks++; if (ibus_drop !== 1'b0) begin errors++; $display("FAIL iflush_no_discard got %b exp 0", ibus_drop); end
    endtask

    task automatic test_back_to_back;
        apply(0, 0, 0, 0, 0, 0, 0, 1, 32'h80000100);
        checks++; if (flush !== 1'b1 || flush_pc !== 32'h80000100) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/80000100", flush, flush_pc); end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 32'h80000200);
        checks++; if (flush !== 1'b1 || flush_pc !== 32'h80000200) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/80000200", flush, flush_pc); end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_after got %b exp 0", flush); end
    endtask

    task automatic test_reset_in_dflush;
        apply(0, 0, 0, 0, 0, 1, 0, 1, 32'hBFC00380);
        apply(0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        apply(1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (stall !== 6'b0 || flush !== 1'b0 || ibus_drop !== 1'b0) begin errors++; $display("FAIL rst_dflush_idle got %b/%b/%b exp 0/0/0", stall, flush, ibus_drop); end
        apply(0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_dflush_lost got %b exp 0", flush); end
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL rst_dflush_stall got %b exp 0", stall); end
    endtask

    task automatic test_counters;
        logic [31:0] exp_sc, exp_fc;
`ifdef PIPE_STALL_CNT_EN
        exp_sc = 32'd5; exp_fc = 32'd1;
`else
        exp_sc = 32'd0; exp_fc = 32'd0;
`endif
        apply(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 32'h80000180);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL cnt_stall got %0d exp %0d", stall_cycles, exp_sc); end
        checks++; if (flush_count !== exp_fc) begin errors++; $display("FAIL cnt_flush got %0d exp %0d", flush_count, exp_fc); end
    endtask

    // Reference: the controller holds while a data access it has seen is unfinished;
    // one exception may be parked behind it and is released on the data return.
    task automatic test_random;
        bit          mem_hold = 0, exc_pend = 0, orphan = 0;
        logic [31:0] pend_pc = 0, scnt = 0, fcnt = 0;
        bit          d_act = 0, i_act = 0;
        int          d_lat = 0, i_lat = 0;
        bit          rst, id, exe, ireq, iok, dreq, dok, exc, blocked, accept, fire;
        logic [31:0] pc, e_pc, e_sc, e_fc;
        logic [5:0]  e_st;
        bit          e_dr;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!d_act && ($urandom % 3 == 0)) begin d_act = 1; d_lat = $urandom_range(0, 3); end
            if (!i_act && ($urandom % 2 == 0)) begin i_act = 1; i_lat = $urandom_range(0, 3); end
            dreq = d_act; dok = d_act && (d_lat == 0);
            ireq = i_act; iok = i_act && (i_lat == 0);
            rst = ($urandom % 90 == 0);
            id = ($urandom % 4 == 0); exe = ($urandom % 5 == 0);
            exc = ($urandom % 6 == 0) && !dok; pc = $urandom;
            apply(rst, id, exe, ireq, iok, dreq, dok, exc, pc);
            if (rst) begin
                e_st = 0; e_dr = 0; fire = 0; e_pc = PC_RST; e_sc = 0; e_fc = 0;
                mem_hold = 0; exc_pend = 0; orphan = 0; scnt = 0; fcnt = 0;
            end else begin
                blocked = mem_hold ? !dok : (dreq && !dok);
                accept  = exc && !exc_pend;
                fire    = (exc_pend && dok) || (accept && !blocked);
                e_pc    = fire ? (exc_pend ? pend_pc : pc) : 32'h0;
                if (fire) e_st = 6'b000000;
                else if (blocked) e_st = 6'b011111;
                else if (exe) e_st = 6'b001111;
                else if (id) e_st = 6'b000111;
                else if ((ireq || orphan) && !iok) e_st = 6'b000011;
                else e_st = 6'b000000;
                e_dr = iok && (orphan || fire);
`ifdef PIPE_STALL_CNT_EN
                e_sc = scnt; e_fc = fcnt;
`else
                e_sc = 0; e_fc = 0;
`endif
                if (accept && blocked) begin exc_pend = 1; pend_pc = pc; end
                else if (exc_pend && dok) exc_pend = 0;
                mem_hold = blocked;
                if (iok) orphan = 0; else if (fire && ireq) orphan = 1;
                scnt += {31'd0, e_st[0]};
                fcnt += {31'd0, fire};
            end
            checks++; if (stall !== e_st) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, stall, e_st); end
            checks++; if (flush !== fire) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", cyc, flush, fire); end
            checks++; if (flush_pc !== e_pc) begin errors++; $display("FAIL rnd_flush_pc cyc %0d got %h exp %h", cyc, flush_pc, e_pc); end
            checks++; if (ibus_drop !== e_dr) begin errors++; $display("FAIL rnd_drop cyc %0d got %b exp %b", cyc, ibus_drop, e_dr); end
            checks++; if (stall_cycles !== e_sc) begin errors++; $display("FAIL rnd_scnt cyc %0d got %0d exp %0d", cyc, stall_cycles, e_sc); end
            checks++; if (flush_count !== e_fc) begin errors++; $display("FAIL rnd_fcnt cyc %0d got %0d exp %0d", cyc, flush_count, e_fc); end
            if (dok) d_act = 0; else if (d_act) d_lat--;
            if (iok) i_act = 0; else if (i_act) i_lat--;
        end
    endtask

    initial begin
        cpu_rst_n = 1; stallreq_id = 0; stallreq_exe = 0;
        ibus_req = 0; ibus_data_ok = 0; dbus_req = 0; dbus_data_ok = 0;
        exc_valid = 0; exc_pc = 0;
        test_reset;
        test_id_stall;
        test_exe_priority;
        test_dbus_exc;
        test_ibus_flush;
        test_back_to_back;
        test_reset_in_dflush;
        test_counters;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
